// File: rtl/seg7_scan_counter.sv
// N-digit BCD up/down event counter with prescaled step,
// parallel load and a multiplexed 7-segment display scanner.
module seg7_scan_counter #(
   parameter int DIGITS       = 4,
   parameter int TICK_DIV     = 1000000,
   parameter int SCAN_DIV     = 1000,
   parameter int BLANK_LZ     = 1,
   parameter int COMMON_ANODE = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  up_dn,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   count_bcd,
   output logic                  tick,
   output logic                  wrap,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     dig_sel
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int SW = $clog2(SCAN_DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] S_LAST = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);
   localparam logic [6:0] SEG0 =
      (COMMON_ANODE != 0) ? 7'b1000000 : 7'b0111111;
   localparam logic [DIGITS-1:0] SEL0 =
      (COMMON_ANODE != 0) ? ~DIGITS'(1) : DIGITS'(1);

   logic [4*DIGITS-1:0] r_count;
   logic [PW-1:0]       r_pre;
   logic [SW-1:0]       r_sc;
   logic [IW-1:0]       r_idx;
   logic                r_tick;
   logic                r_wrap;
   logic [6:0]          r_seg;
   logic [DIGITS-1:0]   r_sel;

   logic [4*DIGITS-1:0] w_next;
   logic [4*DIGITS-1:0] w_load;
   logic                w_all9;
   logic                w_all0;
   logic                w_cy;
   logic [3:0]          w_d;
   logic [3:0]          w_dig;
   logic                w_nz;
   logic [6:0]          w_seg;
   logic [DIGITS-1:0]   w_sel;

   function automatic logic [6:0] dec(input logic [3:0] d);
      case (d)
         4'd0:    dec = 7'b0111111;
         4'd1:    dec = 7'b0000110;
         4'd2:    dec = 7'b1011011;
         4'd3:    dec = 7'b1001111;
         4'd4:    dec = 7'b1100110;
         4'd5:    dec = 7'b1101101;
         4'd6:    dec = 7'b1111101;
         4'd7:    dec = 7'b0000111;
         4'd8:    dec = 7'b1111111;
         4'd9:    dec = 7'b1101111;
         default: dec = 7'b0000000;
      endcase
   endfunction

   // Ripple carry/borrow through the BCD digits
   always_comb begin
      w_next = r_count;
      w_load = '0;
      w_all9 = 1'b1;
      w_all0 = 1'b1;
      w_cy   = 1'b1;
      w_d    = '0;
      for (int i = 0; i < DIGITS; i++) begin
         w_d = r_count[4*i +: 4];
         if (w_d != 4'd9) w_all9 = 1'b0;
         if (w_d != 4'd0) w_all0 = 1'b0;
         if (w_cy) begin
            if (up_dn) begin
               w_next[4*i +: 4] =
                  (w_d == 4'd9) ? 4'd0 : w_d + 4'd1;
               w_cy = (w_d == 4'd9);
            end else begin
               w_next[4*i +: 4] =
                  (w_d == 4'd0) ? 4'd9 : w_d - 4'd1;
               w_cy = (w_d == 4'd0);
            end
         end
         w_load[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ?
            4'd9 : load_val[4*i +: 4];
      end
   end

   always_comb begin
      w_dig = '0;
      w_nz  = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (IW'(i) == r_idx) w_dig = r_count[4*i +: 4];
         if (IW'(i) >= r_idx && r_count[4*i +: 4] != 4'd0)
            w_nz = 1'b1;
      end
      w_seg = dec(w_dig);
      if (BLANK_LZ != 0 && r_idx != '0 && !w_nz)
         w_seg = 7'b0000000;
      w_sel = DIGITS'(1) << r_idx;
      if (COMMON_ANODE != 0) begin
         w_seg = ~w_seg;
         w_sel = ~w_sel;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
         r_pre   <= '0;
         r_sc    <= '0;
         r_idx   <= '0;
         r_tick  <= 1'b0;
         r_wrap  <= 1'b0;
         r_seg   <= SEG0;
         r_sel   <= SEL0;
      end else begin
         r_seg  <= w_seg;
         r_sel  <= w_sel;
         r_tick <= 1'b0;
         r_wrap <= 1'b0;
         if (r_sc == S_LAST) begin
            r_sc  <= '0;
            r_idx <= (r_idx == I_LAST) ? '0 : r_idx + 1'b1;
         end else begin
            r_sc <= r_sc + 1'b1;
         end
         if (load) begin
            r_count <= w_load;
            r_pre   <= '0;
         end else if (en) begin
            if (r_pre == P_LAST) begin
               r_pre   <= '0;
               r_count <= w_next;
               r_tick  <= 1'b1;
               r_wrap  <= up_dn ? w_all9 : w_all0;
            end else begin
               r_pre <= r_pre + 1'b1;
            end
         end
      end
   end

   assign count_bcd = r_count;
   assign tick      = r_tick;
   assign wrap      = r_wrap;
   assign seg       = r_seg;
   assign dig_sel   = r_sel;

endmodule
